id_ex_stage: RTL
================

Name: id_ex_stage

Overview:
- ID/EX pipeline register of the 5-stage MIPS pipeline.
- Captures the register-file read data, decoded fields and control bundle from instruction decode, and presents them to execute.
- Contains load-use hazard detection with a configurable bubble count.
- Provides a WB→ID bypass, because the register file writes on the clock edge and reads combinationally, so an ID read of a register being written in the same cycle returns the stale value.

Parameters:
- LOAD_USE_STALLS, 1, number of bubbles inserted on a load-use hit (1..7).
- DATA_WIDTH, 32, datapath width.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- id_valid  in  1  ID holds a real instruction
- id_pc  in  32  PC+4 of ID instruction
- id_readData1  in  32  register-file port 1 data (rs)
- id_readData2  in  32  register-file port 2 data (rt)
- id_rs  in  5  instr[25:21]
- id_rt  in  5  instr[20:16]
- id_rd  in  5  instr[15:11]
- id_imm  in  32  sign-extended immediate
- id_ctrl  in  10  control bundle: [0]regWrite [1]memRead [2]memWrite [3]memToReg [4]aluSrc [5]regDst [6]branch [9:7]aluOp
- wb_regWrite  in  1  WB stage writing the register file this cycle
- wb_writeRegister  in  5  WB destination register
- wb_writeData  in  32  WB write data
- flush  in  1  taken branch / redirect: kill ID→EX transfer
- ex_stall  in  1  downstream hold request
- ex_valid  out  1  EX holds a real instruction
- ex_pc, ex_readData1, ex_readData2, ex_imm  out  32 each  registered copies
- ex_rs, ex_rt, ex_rd  out  5 each  registered copies
- ex_ctrl  out  10  registered control bundle
- hazard_stall  out  1  hold PC and IF/ID this cycle

Behaviour:
- Reset (sync, highest priority): all ex_* outputs are 0, stall_cnt is 0, and hazard_stall is 0 in the cycle after reset is sampled. Reset mid-stall aborts the stall.
- WB bypass (combinational, on the capture path): src1 = wb_writeData if wb_regWrite && wb_writeRegister==id_rs && id_rs!=0, else id_readData1. src2 is the same using id_rt. Register 0 is never bypassed.
- load_use_hit = ex_valid && ex_ctrl[1] && ex_rt!=0 && id_valid && (ex_rt==id_rs || ex_rt==id_rt).
- FSM is encoded by the 3-bit stall_cnt:
  - RUN: stall_cnt==0.
  - STALL: stall_cnt!=0.
- Per-edge priority is reset > flush > ex_stall > bubble > load:
  - flush: ex_valid←0, ex_ctrl←0, stall_cnt←0, data fields hold their value. hazard_stall=0 whenever flush=1.
  - ex_stall (no flush): all ex_* registers and stall_cnt hold. hazard_stall=1.
  - RUN && load_use_hit: insert a bubble (ex_valid←0, ex_ctrl←0), then stall_cnt←LOAD_USE_STALLS-1. hazard_stall=1.
  - STALL: insert a bubble, then stall_cnt←stall_cnt-1. hazard_stall=1. While in STALL, load_use_hit is not re-evaluated.
  - Otherwise (load): ex_valid←id_valid, ex_ctrl←id_valid?id_ctrl:0, ex_readData1←src1, ex_readData2←src2, and all other fields are copied. hazard_stall=0.
- Latency: 1 cycle from ID to EX. With LOAD_USE_STALLS=N, a dependent instruction enters EX exactly N+1 cycles after the load enters EX.
- Bubble: only ex_valid and ex_ctrl are cleared; data fields retain their old value and are don't-care.
- id_valid=0 with no hazard: the stage loads a bubble and hazard_stall=0.
- Simultaneous flush and load_use_hit: flush wins; no stall is entered.
- ex_stall during STALL freezes stall_cnt.

Test Plan:
- Reset with id inputs nonzero → all ex_* = 0, hazard_stall=0. Then id_valid=1, id_readData1=0x1234, id_ctrl=0x001 → next cycle ex_readData1=0x1234, ex_valid=1, ex_ctrl=0x001.
- lw $8 in EX (ex_ctrl[1]=1, ex_rt=8), ID has add with id_rs=8, N=1 → hazard_stall=1 for 1 cycle, one bubble (ex_valid=0, ex_ctrl=0), then add loads. Repeat with N=3 → 3 bubbles and hazard_stall high for 3 cycles.
- Load with ex_rt=0 and id_rs=0 → no stall; instruction loads next cycle.
- wb_regWrite=1, wb_writeRegister=5, wb_writeData=0xDEADBEEF, id_rt=5, id_readData2=0x0 → ex_readData2=0xDEADBEEF. Same stimulus with register 0 → ex_readData2 takes id_readData2.
- Load-use hit coincident with flush=1 → ex_valid=0, stall_cnt=0, hazard_stall=0. Next cycle, a new instruction loads normally.
- With N=3, mid-stall (stall_cnt=1) assert ex_stall for 2 cycles → outputs and stall_cnt hold. Release → 1 further bubble, then RUN. Separately, reset during STALL → RUN with outputs zero.

Source files
------------

// File: rtl/id_ex_if.sv
// Bundle between instruction decode, the WB bypass source and the ID/EX register.
// master drives the decode/WB/control side; slave is the pipeline register itself.
interface id_ex_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  id_valid;
  logic [31:0]           id_pc;
  logic [DATA_WIDTH-1:0] id_readData1;
  logic [DATA_WIDTH-1:0] id_readData2;
  logic [4:0]            id_rs;
  logic [4:0]            id_rt;
  logic [4:0]            id_rd;
  logic [DATA_WIDTH-1:0] id_imm;
  logic [9:0]            id_ctrl;

  logic                  wb_regWrite;
  logic [4:0]            wb_writeRegister;
  logic [DATA_WIDTH-1:0] wb_writeData;

  logic                  flush;
  logic                  ex_stall;

  logic                  ex_valid;
  logic [31:0]           ex_pc;
  logic [DATA_WIDTH-1:0] ex_readData1;
  logic [DATA_WIDTH-1:0] ex_readData2;
  logic [DATA_WIDTH-1:0] ex_imm;
  logic [4:0]            ex_rs;
  logic [4:0]            ex_rt;
  logic [4:0]            ex_rd;
  logic [9:0]            ex_ctrl;
  logic                  hazard_stall;

  modport master (
    output id_valid, id_pc, id_readData1, id_readData2, id_rs, id_rt, id_rd, id_imm, id_ctrl,
    output wb_regWrite, wb_writeRegister, wb_writeData,
    output flush, ex_stall,
    input  ex_valid, ex_pc, ex_readData1, ex_readData2, ex_imm, ex_rs, ex_rt, ex_rd, ex_ctrl,
    input  hazard_stall
  );

  modport slave (
    input  id_valid, id_pc, id_readData1, id_readData2, id_rs, id_rt, id_rd, id_imm, id_ctrl,
    input  wb_regWrite, wb_writeRegister, wb_writeData,
    input  flush, ex_stall,
    output ex_valid, ex_pc, ex_readData1, ex_readData2, ex_imm, ex_rs, ex_rt, ex_rd, ex_ctrl,
    output hazard_stall
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with WB->ID bypass and load-use bubble insertion.
// The stall counter doubles as the FSM state: zero is RUN, nonzero is STALL.
module id_ex_stage #(
  parameter int LOAD_USE_STALLS = 1,
  parameter int DATA_WIDTH      = 32
) (
  input  logic    clk,
  input  logic    reset,
  id_ex_if.slave  bus
);

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } state_t;

  localparam logic [2:0] STALL_RELOAD = 3'(LOAD_USE_STALLS - 1);

  state_t state;

  logic [2:0]            stall_cnt_reg,    stall_cnt_next;
  logic                  ex_valid_reg,     ex_valid_next;
  logic [9:0]            ex_ctrl_reg,      ex_ctrl_next;
  logic [31:0]           ex_pc_reg,        ex_pc_next;
  logic [DATA_WIDTH-1:0] ex_readData1_reg, ex_readData1_next;
  logic [DATA_WIDTH-1:0] ex_readData2_reg, ex_readData2_next;
  logic [DATA_WIDTH-1:0] ex_imm_reg,       ex_imm_next;
  logic [4:0]            ex_rs_reg,        ex_rs_next;
  logic [4:0]            ex_rt_reg,        ex_rt_next;
  logic [4:0]            ex_rd_reg,        ex_rd_next;
  logic                  hazard_stall_comb;
  logic                  load_use_hit;

  logic [DATA_WIDTH-1:0] rf_data [2];
  logic [4:0]            rf_addr [2];
  logic [DATA_WIDTH-1:0] src     [2];

  assign rf_data[0] = bus.id_readData1;
  assign rf_data[1] = bus.id_readData2;
  assign rf_addr[0] = bus.id_rs;
  assign rf_addr[1] = bus.id_rt;

  // The register file writes on the edge, so a same-cycle read is stale; forward WB data.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_bypass
      assign src[gi] = (bus.wb_regWrite && (bus.wb_writeRegister == rf_addr[gi]) &&
                        (rf_addr[gi] != 5'd0)) ? bus.wb_writeData : rf_data[gi];
    end
  endgenerate

  assign load_use_hit = ex_valid_reg && ex_ctrl_reg[1] && (ex_rt_reg != 5'd0) && bus.id_valid &&
                        ((ex_rt_reg == bus.id_rs) || (ex_rt_reg == bus.id_rt));

  always_comb begin
    state = (stall_cnt_reg == 3'd0) ? RUN : STALL;
  end

  always_comb begin
    stall_cnt_next    = stall_cnt_reg;
    ex_valid_next     = ex_valid_reg;
    ex_ctrl_next      = ex_ctrl_reg;
    ex_pc_next        = ex_pc_reg;
    ex_readData1_next = ex_readData1_reg;
    ex_readData2_next = ex_readData2_reg;
    ex_imm_next       = ex_imm_reg;
    ex_rs_next        = ex_rs_reg;
    ex_rt_next        = ex_rt_reg;
    ex_rd_next        = ex_rd_reg;
    hazard_stall_comb = 1'b0;

    if (bus.flush) begin
      ex_valid_next  = 1'b0;
      ex_ctrl_next   = 10'd0;
      stall_cnt_next = 3'd0;
    end else if (bus.ex_stall) begin
      hazard_stall_comb = 1'b1;
    end else begin
      case (state)
        STALL: begin
          ex_valid_next     = 1'b0;
          ex_ctrl_next      = 10'd0;
          stall_cnt_next    = stall_cnt_reg - 3'd1;
          hazard_stall_comb = 1'b1;
        end
        default: begin
          if (load_use_hit) begin
            ex_valid_next     = 1'b0;
            ex_ctrl_next      = 10'd0;
            stall_cnt_next    = STALL_RELOAD;
            hazard_stall_comb = 1'b1;
          end else begin
            ex_valid_next     = bus.id_valid;
            ex_ctrl_next      = bus.id_valid ? bus.id_ctrl : 10'd0;
            ex_pc_next        = bus.id_pc;
            ex_readData1_next = src[0];
            ex_readData2_next = src[1];
            ex_imm_next       = bus.id_imm;
            ex_rs_next        = bus.id_rs;
            ex_rt_next        = bus.id_rt;
            ex_rd_next        = bus.id_rd;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_reg    <= 3'd0;
      ex_valid_reg     <= 1'b0;
      ex_ctrl_reg      <= 10'd0;
      ex_pc_reg        <= 32'd0;
      ex_readData1_reg <= '0;
      ex_readData2_reg <= '0;
      ex_imm_reg       <= '0;
      ex_rs_reg        <= 5'd0;
      ex_rt_reg        <= 5'd0;
      ex_rd_reg        <= 5'd0;
    end else begin
      stall_cnt_reg    <= stall_cnt_next;
      ex_valid_reg     <= ex_valid_next;
      ex_ctrl_reg      <= ex_ctrl_next;
      ex_pc_reg        <= ex_pc_next;
      ex_readData1_reg <= ex_readData1_next;
      ex_readData2_reg <= ex_readData2_next;
      ex_imm_reg       <= ex_imm_next;
      ex_rs_reg        <= ex_rs_next;
      ex_rt_reg        <= ex_rt_next;
      ex_rd_reg        <= ex_rd_next;
    end
  end

  assign bus.ex_valid     = ex_valid_reg;
  assign bus.ex_ctrl      = ex_ctrl_reg;
  assign bus.ex_pc        = ex_pc_reg;
  assign bus.ex_readData1 = ex_readData1_reg;
  assign bus.ex_readData2 = ex_readData2_reg;
  assign bus.ex_imm       = ex_imm_reg;
  assign bus.ex_rs        = ex_rs_reg;
  assign bus.ex_rt        = ex_rt_reg;
  assign bus.ex_rd        = ex_rd_reg;
  assign bus.hazard_stall = hazard_stall_comb;

endmodule
